// File: rtl/program_loader.sv
// Hardware instruction preloader: turns a framed byte stream (count, words, checksum)
// into instruction-memory writes and releases the core only once the checksum verifies.
module program_loader #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [WIDTH-1:0]     instr_in,
  output logic [$clog2(SIZE)+1:0] instr_wr_addr,
  output logic                 instr_wr_en,
  output logic                 core_reset,
  output logic                 done,
  output logic                 error
);

  localparam int BYTES   = WIDTH / 8;
  localparam int LOGSIZE = $clog2(SIZE);
  localparam int BCW     = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    CHECK,
    RUN,
    ERROR
  } state_t;

  state_t               state;
  logic [BCW-1:0]       byte_cnt;
  logic [WIDTH-9:0]     shift_reg;
  logic [LOGSIZE:0]     word_idx;
  logic [LOGSIZE:0]     word_cnt;
  logic [WIDTH-1:0]     checksum;

  logic                 accept;
  logic                 last_byte;
  logic [WIDTH-1:0]     word;

  assign s_ready   = (state == HEADER) || (state == DATA) || (state == CHECK);
  assign accept    = s_valid && s_ready;
  assign last_byte = (byte_cnt == BCW'(BYTES - 1));
  // The final byte of a word goes straight to the top lane; the lower lanes are already held.
  assign word      = {s_data, shift_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      shift_reg     <= '0;
      word_idx      <= '0;
      word_cnt      <= '0;
      checksum      <= '0;
      instr_in      <= '0;
      instr_wr_addr <= '0;
      instr_wr_en   <= 1'b0;
      core_reset    <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      instr_wr_en <= 1'b0;
      if (start && (state == IDLE || state == RUN || state == ERROR)) begin
        state      <= HEADER;
        byte_cnt   <= '0;
        word_idx   <= '0;
        checksum   <= '0;
        core_reset <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
      end else if (accept) begin
        if (!last_byte) begin
          shift_reg[{byte_cnt, 3'b000} +: 8] <= s_data;
          byte_cnt <= byte_cnt + 1'b1;
        end else begin
          byte_cnt <= '0;
          case (state)
            HEADER: begin
              if (word == '0 || word > WIDTH'(SIZE)) begin
                state <= ERROR;
                error <= 1'b1;
              end else begin
                word_cnt <= word[LOGSIZE:0];
                state    <= DATA;
              end
            end
            DATA: begin
              instr_in      <= word;
              instr_wr_addr <= {word_idx[LOGSIZE-1:0], 2'b00};
              instr_wr_en   <= 1'b1;
              checksum      <= checksum + word;
              word_idx      <= word_idx + 1'b1;
              if (word_idx + 1'b1 == word_cnt) state <= CHECK;
            end
            CHECK: begin
              if (word == checksum) begin
                state      <= RUN;
                done       <= 1'b1;
                core_reset <= 1'b0;
              end else begin
                state <= ERROR;
                error <= 1'b1;
              end
            end
            default: state <= state;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of framed loads plus hand-built corner sequences.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] instr_in;
  logic [7:0]  instr_wr_addr;
  logic        instr_wr_en;
  logic        core_reset;
  logic        done;
  logic        error;

  program_loader #(.WIDTH(32), .SIZE(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .instr_in      (instr_in),
    .instr_wr_addr (instr_wr_addr),
    .instr_wr_en   (instr_wr_en),
    .core_reset    (core_reset),
    .done          (done),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] n;
    logic [31:0] w0, w1, w2;
    logic [31:0] csum;
    int          gapMode;
    logic        expDone;
    logic        expError;
    int          expWrites;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] frameWords[64];
  logic [7:0]  addrQ[$];
  logic [31:0] dataQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          sreadyBad = 0;

  // Log every write strobe and catch s_ready asserted while the loader reports RUN/ERROR.
  always @(negedge clk) begin
    if (instr_wr_en) begin
      addrQ.push_back(instr_wr_addr);
      dataQ.push_back(instr_in);
    end
    if (s_ready && (done || error)) sreadyBad++;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapMode);
    int idle;
    int t;
    idle = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 5)) : 0;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) checkOutput("s_ready timeout", {31'b0, s_ready}, 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] w, input int gapMode);
    for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8], gapMode);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic checkWrites(input string tag, input int expWrites);
    checkOutput($sformatf("%s write count", tag), addrQ.size(), expWrites);
    for (int i = 0; i < expWrites && i < addrQ.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), {24'b0, addrQ[i]}, i * 4);
      checkOutput($sformatf("%s data[%0d]", tag, i), dataQ[i], frameWords[i]);
    end
  endtask

  // One framed load: start, header, data words, checksum, then status and write checks.
  task automatic applyStimulus(input string tag, input logic [31:0] n, input logic [31:0] csum,
                               input int gapMode, input logic expDone, input logic expError,
                               input int expWrites, input int startAfterWord);
    addrQ.delete();
    dataQ.delete();
    pulseStart();
    checkOutput($sformatf("%s core_reset after start", tag), {31'b0, core_reset}, 32'd1);
    checkOutput($sformatf("%s done after start", tag), {31'b0, done}, 32'd0);
    checkOutput($sformatf("%s error after start", tag), {31'b0, error}, 32'd0);
    sendWord(n, gapMode);
    if (n >= 1 && n <= 64) begin
      for (int i = 0; i < int'(n); i++) begin
        sendWord(frameWords[i], gapMode);
        if (i == startAfterWord) pulseStart();
      end
      sendWord(csum, gapMode);
    end
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput($sformatf("%s done", tag), {31'b0, done}, {31'b0, expDone});
    checkOutput($sformatf("%s error", tag), {31'b0, error}, {31'b0, expError});
    checkOutput($sformatf("%s core_reset", tag), {31'b0, core_reset}, {31'b0, !expDone});
    checkOutput($sformatf("%s s_ready", tag), {31'b0, s_ready}, 32'd0);
    checkWrites(tag, expWrites);
  endtask

  initial begin
    logic [31:0] sum;

    vecs[0] = '{32'd3,  32'h00000013, 32'h00100093, 32'h00208113, 32'h003081B9, 0, 1'b1, 1'b0, 3};
    vecs[1] = '{32'd3,  32'h00000013, 32'h00100093, 32'h00208113, 32'h003081B8, 0, 1'b0, 1'b1, 3};
    vecs[2] = '{32'd0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b1, 0};
    vecs[3] = '{32'd65, 32'h0,        32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b1, 0};
    vecs[4] = '{32'd3,  32'h00000013, 32'h00100093, 32'h00208113, 32'h003081B9, 1, 1'b1, 1'b0, 3};
    vecs[5] = '{32'd3,  32'h00000013, 32'h00100093, 32'h00208113, 32'h003081B9, 2, 1'b1, 1'b0, 3};
    vecs[6] = '{32'd1,  32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 0, 1'b1, 1'b0, 1};

    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset s_ready", {31'b0, s_ready}, 32'd0);
    checkOutput("reset instr_in", instr_in, 32'd0);
    checkOutput("reset addr", {24'b0, instr_wr_addr}, 32'd0);
    checkOutput("reset wr_en", {31'b0, instr_wr_en}, 32'd0);
    checkOutput("reset core_reset", {31'b0, core_reset}, 32'd1);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset error", {31'b0, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      frameWords[0] = vecs[v].w0;
      frameWords[1] = vecs[v].w1;
      frameWords[2] = vecs[v].w2;
      applyStimulus($sformatf("vec%0d", v), vecs[v].n, vecs[v].csum, vecs[v].gapMode,
                    vecs[v].expDone, vecs[v].expError, vecs[v].expWrites, -1);
    end

    // start pulsed mid-DATA must not disturb the load
    frameWords[0] = 32'h00000013;
    frameWords[1] = 32'h00100093;
    frameWords[2] = 32'h00208113;
    applyStimulus("startInData", 32'd3, 32'h003081B9, 0, 1'b1, 1'b0, 3, 0);

    // full-depth load
    sum = 32'd0;
    for (int i = 0; i < 64; i++) begin
      frameWords[i] = 32'h10000000 + i * 32'h00000101;
      sum = sum + frameWords[i];
    end
    applyStimulus("full64", 32'd64, sum, 0, 1'b1, 1'b0, 64, -1);
    checkOutput("full64 last addr", {24'b0, addrQ[addrQ.size()-1]}, 32'd252);

    // reset after six bytes (header + two data bytes)
    addrQ.delete();
    dataQ.delete();
    pulseStart();
    sendWord(32'd3, 0);
    sendByte(8'h13, 0);
    sendByte(8'h00, 0);
    @(negedge clk);
    s_valid = 1'b0;
    reset   = 1'b1;
    #1;
    checkOutput("midReset s_ready", {31'b0, s_ready}, 32'd0);
    checkOutput("midReset instr_in", instr_in, 32'd0);
    checkOutput("midReset addr", {24'b0, instr_wr_addr}, 32'd0);
    checkOutput("midReset wr_en", {31'b0, instr_wr_en}, 32'd0);
    checkOutput("midReset core_reset", {31'b0, core_reset}, 32'd1);
    checkOutput("midReset done", {31'b0, done}, 32'd0);
    checkOutput("midReset error", {31'b0, error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midReset write count", addrQ.size(), 32'd0);
    frameWords[0] = 32'h00000013;
    frameWords[1] = 32'h00100093;
    frameWords[2] = 32'h00208113;
    applyStimulus("afterReset", 32'd3, 32'h003081B9, 0, 1'b1, 1'b0, 3, -1);

    checkOutput("s_ready outside load", sreadyBad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
